// File: rtl/ctrl_uart_rx.sv
// 8N1 UART receiver and fixed-length control-frame parser; `out` updates only on a complete, valid frame.
// Define CTRL_CHECKSUM_EN to require a trailing XOR checksum byte after the data bytes.
//
// byte fsm  | meaning
// B_IDLE    | line idle, waiting for a falling edge on rx_s
// B_START   | waiting half a bit, then confirming the start bit
// B_DATA    | sampling 8 data bits, LSB first
// B_STOP    | sampling the stop bit
// B_BREAK   | framing error seen, waiting for the line to return high
//
// frame fsm   | meaning
// F_WAIT_SYNC | discarding bytes until SYNC
// F_DATA      | storing N_CH data bytes into the shadow registers
// F_CHK       | comparing the checksum byte with the running XOR
module ctrl_uart_rx #(
    parameter int         FCLK        = 50_000_000,
    parameter int         BAUD        = 115_200,
    parameter int         N_CH        = 7,
    parameter logic [7:0] SYNC        = 8'hA5,
    parameter int         TIMEOUT_CYC = 50_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ctrl_rx,
    output logic [7:0] out [0:N_CH-1],
    output logic       out_valid,
    output logic       frame_err
);

    localparam int BIT_DIV  = FCLK / BAUD;
    localparam int HALF_DIV = BIT_DIV / 2;
    localparam int DIV_W    = $clog2(BIT_DIV);
    localparam int TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_STOP, B_BREAK} bstate_e;
    typedef enum logic [1:0] {F_WAIT_SYNC, F_DATA, F_CHK} fstate_e;

    logic             sync1_q;
    logic             rx_s_q;
    logic             rx_s;
    logic [1:0]       warm_q;
    logic             rx_prev_q;
    logic             rx_prev_d;
    logic             fall;

    bstate_e          bstate_q, bstate_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             byte_rdy_q, byte_rdy_d;
    logic             byte_err_q, byte_err_d;
    logic             div_done;

    fstate_e          fstate_q, fstate_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       shadow_q [0:N_CH-1];
    logic [7:0]       shadow_d [0:N_CH-1];
    logic [7:0]       out_q [0:N_CH-1];
    logic [7:0]       out_d [0:N_CH-1];
    logic             out_valid_q, out_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_hit;
    logic             last_ch;
`ifdef CTRL_CHECKSUM_EN
    logic [7:0]       xor_q, xor_d;
`endif

    // rx_prev only reports a high line once the synchroniser holds real samples,
    // so a line that is low at reset release cannot fake a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            warm_q    <= 2'b00;
            rx_prev_q <= 1'b0;
        end else begin
            sync1_q   <= ctrl_rx;
            rx_s_q    <= sync1_q;
            warm_q    <= {warm_q[0], 1'b1};
            rx_prev_q <= rx_prev_d;
        end
    end

    assign rx_s      = rx_s_q;
    assign rx_prev_d = warm_q[1] & rx_s;
    assign fall      = rx_prev_q & ~rx_s;
    assign div_done  = (div_q == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bstate_q <= B_IDLE;
        else          bstate_q <= bstate_d;
    end

    always_comb begin
        bstate_d = bstate_q;
        case (bstate_q)
            B_IDLE:  if (fall) bstate_d = B_START;
            B_START: if (div_done) bstate_d = rx_s ? B_IDLE : B_DATA;
            B_DATA:  if (div_done && bit_q == 3'd7) bstate_d = B_STOP;
            B_STOP:  if (div_done) bstate_d = rx_s ? B_IDLE : B_BREAK;
            B_BREAK: if (rx_s) bstate_d = B_IDLE;
            default: bstate_d = B_IDLE;
        endcase
    end

    always_comb begin
        div_d      = div_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        byte_rdy_d = 1'b0;
        byte_err_d = 1'b0;
        case (bstate_q)
            B_IDLE: if (fall) div_d = DIV_W'(HALF_DIV - 1);
            B_START: begin
                if (div_done) begin
                    div_d = DIV_W'(BIT_DIV - 1);
                    bit_d = 3'd0;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            B_DATA: begin
                if (div_done) begin
                    shreg_d = {rx_s, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    div_d   = DIV_W'(BIT_DIV - 1);
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            B_STOP: begin
                if (div_done) begin
                    byte_rdy_d = rx_s;
                    byte_err_d = ~rx_s;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            byte_rdy_q <= 1'b0;
            byte_err_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            byte_rdy_q <= byte_rdy_d;
            byte_err_q <= byte_err_d;
        end
    end

    assign tmo_hit = (fstate_q != F_WAIT_SYNC) && (tmo_q == TMO_W'(TIMEOUT_CYC));
    assign last_ch = (idx_q == IDX_W'(N_CH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) fstate_q <= F_WAIT_SYNC;
        else          fstate_q <= fstate_d;
    end

    always_comb begin
        fstate_d = fstate_q;
        if (tmo_hit || byte_err_q) begin
            fstate_d = F_WAIT_SYNC;
        end else if (byte_rdy_q) begin
            case (fstate_q)
                F_WAIT_SYNC: if (shreg_q == SYNC) fstate_d = F_DATA;
`ifdef CTRL_CHECKSUM_EN
                F_DATA:      if (last_ch) fstate_d = F_CHK;
                F_CHK:       fstate_d = F_WAIT_SYNC;
`else
                F_DATA:      if (last_ch) fstate_d = F_WAIT_SYNC;
`endif
                default:     fstate_d = F_WAIT_SYNC;
            endcase
        end
    end

    // Without the checksum the commit happens on the last data byte itself,
    // so the committed set comes from shadow_d, which already holds that byte.
    always_comb begin
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        frame_err_d = tmo_hit | byte_err_q;
        tmo_d       = (fstate_q == F_WAIT_SYNC || byte_rdy_q || tmo_hit) ? '0 : tmo_q + 1'b1;
`ifdef CTRL_CHECKSUM_EN
        xor_d       = xor_q;
`endif
        if (byte_rdy_q && !tmo_hit && !byte_err_q) begin
            case (fstate_q)
                F_WAIT_SYNC: begin
                    if (shreg_q == SYNC) begin
                        idx_d = '0;
`ifdef CTRL_CHECKSUM_EN
                        xor_d = 8'h00;
`endif
                    end
                end
                F_DATA: begin
                    for (int k = 0; k < N_CH; k++) begin
                        if (idx_q == IDX_W'(k)) shadow_d[k] = shreg_q;
                    end
                    idx_d = idx_q + 1'b1;
`ifdef CTRL_CHECKSUM_EN
                    xor_d = xor_q ^ shreg_q;
`else
                    if (last_ch) begin
                        out_d       = shadow_d;
                        out_valid_d = 1'b1;
                    end
`endif
                end
`ifdef CTRL_CHECKSUM_EN
                F_CHK: begin
                    if (shreg_q == xor_q) begin
                        out_d       = shadow_q;
                        out_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            tmo_q       <= '0;
`ifdef CTRL_CHECKSUM_EN
            xor_q       <= 8'h00;
`endif
            for (int k = 0; k < N_CH; k++) begin
                shadow_q[k] <= 8'h00;
                out_q[k]    <= 8'h00;
            end
        end else begin
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            tmo_q       <= tmo_d;
`ifdef CTRL_CHECKSUM_EN
            xor_q       <= xor_d;
`endif
            shadow_q    <= shadow_d;
            out_q       <= out_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ctrl_uart_rx.sv
// Directed bench for ctrl_uart_rx with a frame scoreboard; runs at a scaled-down bit rate and timeout.
module tb_ctrl_uart_rx;

    localparam int         FCLK = 2_000_000;
    localparam int         BAUD = 62_500;
    localparam int         N_CH = 7;
    localparam int         TMO  = 2_000;
    localparam int         BIT  = FCLK / BAUD;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       ctrl_rx = 1'b1;
    logic [7:0] out_w [0:N_CH-1];
    logic       out_valid;
    logic       frame_err;

    ctrl_uart_rx #(
        .FCLK(FCLK), .BAUD(BAUD), .N_CH(N_CH), .SYNC(SYNC), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ctrl_rx(ctrl_rx),
        .out(out_w), .out_valid(out_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    int err_seen = 0;
    int valid_seen = 0;
    int last_err_cyc = 0;
    int stop_mid_cyc = 0;
    int v0, e0, mark, delta;
    logic [8*N_CH-1:0] exp_q [$];
    logic [8*N_CH-1:0] exp_cur;
    logic [7:0] b3;

    localparam logic [8*N_CH-1:0] F1 = 56'h07060504030201;
    localparam logic [8*N_CH-1:0] F2 = 56'h77665544332211;
    localparam logic [8*N_CH-1:0] F3 = 56'h0D0C0B0A090807;
    localparam logic [8*N_CH-1:0] F4 = 56'hA500A500A500A5;
    localparam logic [8*N_CH-1:0] F5 = 56'h5A3C96C3E1F00F;
    localparam logic [8*N_CH-1:0] F6 = 56'h2B4D6F8091B3C5;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_counts(input string tag, input int dv, input int de);
        chk({tag, "_valid_pulses"}, 32'(valid_seen - v0), 32'(dv));
        chk({tag, "_err_pulses"}, 32'(err_seen - e0), 32'(de));
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard side: every out_valid must match the oldest frame still expected.
    always @(negedge clk) begin
        if (frame_err) begin
            err_seen++;
            last_err_cyc = cyc;
        end
        if (out_valid) begin
            valid_seen++;
            chk("out_valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_cur = exp_q.pop_front();
                for (int k = 0; k < N_CH; k++)
                    chk($sformatf("out_ch%0d", k), 32'(out_w[k]), 32'(exp_cur[8*k +: 8]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        ctrl_rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            ctrl_rx = b[i];
            tick(BIT);
        end
        ctrl_rx = stop;
        tick(BIT / 2);
        stop_mid_cyc = cyc;
        tick(BIT - BIT / 2);
        ctrl_rx = 1'b1;
    endtask

    task automatic send_frame(input logic [8*N_CH-1:0] d);
        logic [7:0] cs;
        cs = 8'h00;
        send_byte(SYNC, 1'b1);
        for (int k = 0; k < N_CH; k++) begin
            send_byte(d[8*k +: 8], 1'b1);
            cs = cs ^ d[8*k +: 8];
        end
`ifdef CTRL_CHECKSUM_EN
        send_byte(cs, 1'b1);
`endif
    endtask

    initial begin
        reset_n = 1'b0;
        ctrl_rx = 1'b1;
        tick(5);
        for (int k = 0; k < N_CH; k++) chk("reset_out", 32'(out_w[k]), 32'h0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        reset_n = 1'b1;
        tick(3 * BIT);

        v0 = valid_seen; e0 = err_seen;
        exp_q.push_back(F1);
        send_frame(F1);
        tick(2 * BIT);
        chk_counts("clean", 1, 0);

`ifdef CTRL_CHECKSUM_EN
        v0 = valid_seen; e0 = err_seen;
        send_byte(SYNC, 1'b1);
        for (int k = 0; k < N_CH; k++) send_byte(F1[8*k +: 8], 1'b1);
        send_byte(8'hFF, 1'b1);
        tick(2 * BIT);
        chk_counts("bad_checksum", 0, 1);
        for (int k = 0; k < N_CH; k++) chk("bad_checksum_hold", 32'(out_w[k]), 32'(F1[8*k +: 8]));
`endif

        v0 = valid_seen; e0 = err_seen;
        ctrl_rx = 1'b0;
        tick(6);
        ctrl_rx = 1'b1;
        tick(3 * BIT);
        chk_counts("glitch", 0, 0);

        // Framing error in the middle of a frame must abort it.
        v0 = valid_seen; e0 = err_seen;
        send_byte(SYNC, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h55, 1'b0);
        tick(2 * BIT);
        chk_counts("framing_error", 0, 1);
        v0 = valid_seen; e0 = err_seen;
        exp_q.push_back(F2);
        send_frame(F2);
        tick(2 * BIT);
        chk_counts("after_framing_error", 1, 0);

        v0 = valid_seen; e0 = err_seen;
        send_byte(SYNC, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b1);
        mark = stop_mid_cyc;
        for (int i = 0; i < TMO + 4 * BIT && err_seen == e0; i++) tick(1);
        chk_counts("timeout", 0, 1);
        delta = last_err_cyc - mark;
        chk($sformatf("timeout_delay_%0d_cycles_in_window", delta),
            32'(delta >= TMO && delta <= TMO + 16), 32'd1);
        tick(TMO / 5);
        v0 = valid_seen; e0 = err_seen;
        exp_q.push_back(F3);
        send_frame(F3);
        tick(2 * BIT);
        chk_counts("after_timeout", 1, 0);

        v0 = valid_seen; e0 = err_seen;
        exp_q.push_back(F4);
        exp_q.push_back(F5);
        send_frame(F4);
        send_frame(F5);
        tick(2 * BIT);
        chk_counts("sync_in_data_back_to_back", 2, 0);

        // Reset pulse during data bit 4 of the third data byte.
        v0 = valid_seen; e0 = err_seen;
        b3 = 8'h03;
        send_byte(SYNC, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        ctrl_rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 4; i++) begin
            ctrl_rx = b3[i];
            tick(BIT);
        end
        ctrl_rx = b3[4];
        tick(BIT / 2);
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < N_CH; k++) chk("reset_mid_out", 32'(out_w[k]), 32'h0);
        chk("reset_mid_out_valid", 32'(out_valid), 32'd0);
        tick(3);
        reset_n = 1'b1;
        tick(BIT - BIT / 2 - 3);
        for (int i = 5; i < 8; i++) begin
            ctrl_rx = b3[i];
            tick(BIT);
        end
        ctrl_rx = 1'b1;
        tick(3 * BIT);
        chk_counts("reset_mid_byte", 0, 0);
        v0 = valid_seen; e0 = err_seen;
        exp_q.push_back(F6);
        send_frame(F6);
        tick(2 * BIT);
        chk_counts("after_reset", 1, 0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
